two_demux_scan_1_to_4: RTL and testbench

- Receiving end of a dual 4-to-1 multiplexed line pair: drives select (a1,a0) and active-low strobes to a remote dual 4-input mux, then samples its y1/y2 outputs.
- De-multiplexes each line back into four registered bits per channel.
- Used in the digital clock to read back scanned signal groups through one mux package.
- Waits a settle period per slot to cover mux propagation delay.

---
 rtl/two_demux_scan_1_to_4.sv | 163 ++++++++++++++++
 tb/tb_two_demux_scan_1_to_4.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/two_demux_scan_1_to_4.sv
`default_nettype none
// ============================================================================
// Module      : two_demux_scan_1_to_4
// Description : Scans a remote dual 4-input mux. Drives select (a1,a0) and
//               active-low strobes, waits a settle period per slot, samples
//               y1/y2 and commits four bits per channel atomically per frame.
//               Optional macro TWO_DEMUX_VOTE_EN: three samples per slot with
//               a 2-of-3 majority vote.
// Revision    : 1.0 - initial release
// ============================================================================
module two_demux_scan_1_to_4 #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       y1,
  input  logic       y2,
  output logic       a1,
  output logic       a0,
  output logic       s1_n,
  output logic       s2_n,
  output logic [3:0] q_1,
  output logic [3:0] q_2,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [7:0] C_RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] slot;
  logic [3:0] sh_1;
  logic [3:0] sh_2;

  logic       w_bit_1;
  logic       w_bit_2;
  logic       w_last;
  logic [3:0] w_nsh_1;
  logic [3:0] w_nsh_2;

`ifdef TWO_DEMUX_VOTE_EN
  logic [1:0] vcnt;
  logic [1:0] hist_1;
  logic [1:0] hist_2;

  // Majority over the two held samples and the sample at the current edge.
  always_comb begin
    w_last  = (vcnt == 2'd2);
    w_bit_1 = (hist_1[1] & hist_1[0]) | (hist_1[1] & y1) | (hist_1[0] & y1);
    w_bit_2 = (hist_2[1] & hist_2[0]) | (hist_2[1] & y2) | (hist_2[0] & y2);
  end

  // Collect the first two of three samples taken during SAMPLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      vcnt   <= 2'd0;
      hist_1 <= 2'b00;
      hist_2 <= 2'b00;
    end else if (state == SAMPLE) begin
      vcnt   <= w_last ? 2'd0 : vcnt + 2'd1;
      hist_1 <= {hist_1[0], y1};
      hist_2 <= {hist_2[0], y2};
    end else begin
      vcnt <= 2'd0;
    end
  end
`else
  // Single sample: the value at the SAMPLE ending edge is taken directly.
  always_comb begin
    w_last  = 1'b1;
    w_bit_1 = y1;
    w_bit_2 = y2;
  end
`endif

  // Shadow images with the current slot's bit merged in.
  always_comb begin
    w_nsh_1       = sh_1;
    w_nsh_2       = sh_2;
    w_nsh_1[slot] = w_bit_1;
    w_nsh_2[slot] = w_bit_2;
  end

  // Scan sequencer: select/strobe drive, settle timing, sample and commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      slot       <= 2'd0;
      sh_1       <= 4'b0000;
      sh_2       <= 4'b0000;
      q_1        <= 4'b0000;
      q_2        <= 4'b0000;
      a1         <= 1'b0;
      a0         <= 1'b0;
      s1_n       <= 1'b1;
      s2_n       <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start || cont) begin
            state      <= SETTLE;
            slot       <= 2'd0;
            {a1, a0}   <= 2'b00;
            s1_n       <= 1'b0;
            s2_n       <= 1'b0;
            busy       <= 1'b1;
            cnt        <= C_RELOAD;
          end
        end
        SETTLE: begin
          if (cnt == 8'd0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SAMPLE: begin
          if (w_last) begin
            sh_1 <= w_nsh_1;
            sh_2 <= w_nsh_2;
            cnt  <= C_RELOAD;
            if (slot == 2'd3) begin
              // Whole frame is published in one edge; no partial update.
              q_1        <= w_nsh_1;
              q_2        <= w_nsh_2;
              frame_done <= 1'b1;
              slot       <= 2'd0;
              {a1, a0}   <= 2'b00;
              if (cont) begin
                state <= SETTLE;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                s1_n  <= 1'b1;
                s2_n  <= 1'b1;
              end
            end else begin
              slot     <= slot + 2'd1;
              {a1, a0} <= slot + 2'd1;
              state    <= SETTLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_two_demux_scan_1_to_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_two_demux_scan_1_to_4
// Description : Self-checking bench for two_demux_scan_1_to_4 with a remote
//               dual-mux model, a frame-timing reference model and directed
//               vectors. Honours TWO_DEMUX_VOTE_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_two_demux_scan_1_to_4;

  localparam int ST = 4;
`ifdef TWO_DEMUX_VOTE_EN
  localparam int NV = 3;
  localparam int FL = 28;
  localparam int NFC = 2;
  localparam int LASTC = 56;
  localparam int GK = 19;
  localparam logic [3:0] GQ = 4'b1111;
`else
  localparam int NV = 1;
  localparam int FL = 20;
  localparam int NFC = 3;
  localparam int LASTC = 60;
  localparam int GK = 14;
  localparam logic [3:0] GQ = 4'b1011;
`endif
  localparam int SL = ST + NV;

  logic       clk = 1'b0;
  logic       rst, start, cont, kill1;
  logic [3:0] d_1, d_2;
  logic       y1, y2, a1, a0, s1_n, s2_n, busy, frame_done;
  logic [3:0] q_1, q_2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Remote dual 4-input mux: output forced low while its strobe is high.
  assign y1 = !s1_n ? (d_1[{a1, a0}] & ~kill1) : 1'b0;
  assign y2 = !s2_n ? d_2[{a1, a0}] : 1'b0;

  two_demux_scan_1_to_4 #(.SETTLE_CYCLES(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .y1(y1), .y2(y2),
    .a1(a1), .a0(a0), .s1_n(s1_n), .s2_n(s2_n), .q_1(q_1), .q_2(q_2),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: frame position counted in cycles since acceptance.
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_t = 0;
  int         m_v1 = 0;
  int         m_v2 = 0;
  logic [3:0] m_q1 = 4'b0, m_q2 = 4'b0, m_sh1 = 4'b0, m_sh2 = 4'b0;

  always @(posedge clk) begin : model
    int ph, sl;
    logic yy1, yy2;
    if (rst) begin
      m_busy = 0; m_done = 0; m_t = 0; m_v1 = 0; m_v2 = 0;
      m_q1 = 4'b0; m_q2 = 4'b0; m_sh1 = 4'b0; m_sh2 = 4'b0;
    end else if (!m_busy) begin
      m_done = 0;
      if (start || cont) begin
        m_busy = 1; m_t = 0; m_v1 = 0; m_v2 = 0;
      end
    end else begin
      m_done = 0;
      ph = m_t % SL;
      sl = m_t / SL;
      yy1 = d_1[sl] & ~kill1;
      yy2 = d_2[sl];
      if (ph >= SL - NV) begin
        m_v1 += int'(yy1);
        m_v2 += int'(yy2);
      end
      if (ph == SL - 1) begin
        m_sh1[sl] = (2 * m_v1 > NV);
        m_sh2[sl] = (2 * m_v2 > NV);
        m_v1 = 0; m_v2 = 0;
        if (sl == 3) begin
          m_q1 = m_sh1; m_q2 = m_sh2; m_done = 1;
          if (cont) m_t = 0;
          else m_busy = 0;
        end else begin
          m_t++;
        end
      end else begin
        m_t++;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : compare
    logic [1:0] esel;
    esel = m_busy ? 2'(m_t / SL) : 2'd0;
    chk("m_busy", {7'b0, busy}, {7'b0, m_busy});
    chk("m_sel", {6'b0, a1, a0}, {6'b0, esel});
    chk("m_s1n", {7'b0, s1_n}, {7'b0, !m_busy});
    chk("m_s2n", {7'b0, s2_n}, {7'b0, !m_busy});
    chk("m_q1", {4'b0, q_1}, {4'b0, m_q1});
    chk("m_q2", {4'b0, q_2}, {4'b0, m_q2});
    chk("m_done", {7'b0, frame_done}, {7'b0, m_done});
  end

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin : stim
    int n, last;
    rst = 1'b1; start = 1'b0; cont = 1'b0; kill1 = 1'b0;
    d_1 = 4'b0000; d_2 = 4'b0000;
    @(negedge clk);
    repeat (3) step();
    chk("rst_q1", {4'b0, q_1}, 8'h00);
    chk("rst_q2", {4'b0, q_2}, 8'h00);
    chk("rst_strobe", {6'b0, s1_n, s2_n}, 8'h03);
    chk("rst_sel", {6'b0, a1, a0}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_done", {7'b0, frame_done}, 8'h00);
    rst = 1'b0;
    step();

    // Single frame with fixed mux data.
    d_1 = 4'b1010; d_2 = 4'b0110;
    pulse_start();
    for (int k = 1; k <= FL; k++) begin
      step();
      chk("done_at", {7'b0, frame_done}, (k == FL) ? 8'h01 : 8'h00);
      if (k == 7) chk("sel_k7", {6'b0, a1, a0}, 8'h01);
      if (k == FL - 1) chk("busy_pre", {7'b0, busy}, 8'h01);
    end
    chk("f1_q1", {4'b0, q_1}, 8'h0A);
    chk("f1_q2", {4'b0, q_2}, 8'h06);
    chk("f1_busy", {7'b0, busy}, 8'h00);
    chk("f1_strobe", {6'b0, s1_n, s2_n}, 8'h03);
    step();

    // Atomic update: preload 1111, then change data mid-frame.
    d_1 = 4'b1111;
    pulse_start();
    repeat (FL) step();
    chk("pre_q1", {4'b0, q_1}, 8'h0F);
    pulse_start();
    for (int k = 1; k <= FL; k++) begin
      step();
      if (k == 8) d_1 = 4'b0000;
      if (k < FL) chk("q1_hold", {4'b0, q_1}, 8'h0F);
    end
    chk("atom_q1", {4'b0, q_1}, 8'h01);
    step();

    // Start while busy is ignored.
    d_1 = 4'b1010;
    pulse_start();
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      start = (k == 3 || k == 12);
      step();
      if (frame_done) n++;
    end
    start = 1'b0;
    chk("one_frame", 8'(n), 8'h01);
    chk("bs_q1", {4'b0, q_1}, 8'h0A);

    // Continuous mode, dropped after edge 45.
    cont = 1'b1;
    step();
    n = 0; last = 0;
    for (int k = 1; k <= 80; k++) begin
      cont = (k < 46);
      step();
      if (frame_done) begin n++; last = k; end
    end
    chk("cont_frames", 8'(n), 8'(NFC));
    chk("cont_last", 8'(last), 8'(LASTC));
    chk("cont_idle", {7'b0, busy}, 8'h00);

    // Reset in the middle of a frame.
    pulse_start();
    for (int k = 1; k <= 13; k++) begin
      rst = (k == 13);
      step();
    end
    chk("mr_q1", {4'b0, q_1}, 8'h00);
    chk("mr_q2", {4'b0, q_2}, 8'h00);
    chk("mr_busy", {7'b0, busy}, 8'h00);
    chk("mr_strobe", {6'b0, s1_n, s2_n}, 8'h03);
    chk("mr_done", {7'b0, frame_done}, 8'h00);
    rst = 1'b0;
    step();
    pulse_start();
    for (int k = 1; k <= FL; k++) begin
      step();
      chk("mr2_done", {7'b0, frame_done}, (k == FL) ? 8'h01 : 8'h00);
    end
    chk("mr2_q1", {4'b0, q_1}, 8'h0A);
    chk("mr2_q2", {4'b0, q_2}, 8'h06);

    // One-cycle low glitch on y1 during a slot-2 sample cycle.
    d_1 = 4'b1111;
    step();
    pulse_start();
    for (int k = 1; k <= FL; k++) begin
      kill1 = (k == GK + 1);
      step();
    end
    kill1 = 1'b0;
    chk("glitch_done", {7'b0, frame_done}, 8'h01);
    chk("glitch_q1", {4'b0, q_1}, {4'b0, GQ});
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
